// File: rtl/capture_ctrl_if.sv
// ============================================================================
// capture_ctrl_if
// Bundle of the control, sample, RAM and transmitter signals of the
// capture/readback controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface capture_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5
);
  localparam int GROUPS = WIDTH / 8;
  localparam int LW     = $clog2(GROUPS + 1);

  logic              arm_i;
  logic              set_cnt_i;
  logic              set_grp_i;
  logic [31:0]       cmd_i;
  logic [GROUPS-1:0] grp_dis_i;
  logic              run_i;
  logic              stb_i;
  logic [WIDTH-1:0]  smpls_i;
  logic              we_o;
  logic [DEPTH-1:0]  addr_o;
  logic [WIDTH-1:0]  mem_o;
  logic [WIDTH-1:0]  mem_i;
  logic              tx_rdy_i;
  logic              tx_stb_o;
  logic [WIDTH-1:0]  tx_o;
  logic [LW-1:0]     tx_len_o;
  logic              tx_sel_o;
  logic              busy_o;

  // Environment side: trigger, sampler, RAM and transmitter
  modport master (
    output arm_i, set_cnt_i, set_grp_i, cmd_i, grp_dis_i, run_i, stb_i,
    output smpls_i, mem_i, tx_rdy_i,
    input  we_o, addr_o, mem_o, tx_stb_o, tx_o, tx_len_o, tx_sel_o, busy_o
  );

  // Controller side
  modport slave (
    input  arm_i, set_cnt_i, set_grp_i, cmd_i, grp_dis_i, run_i, stb_i,
    input  smpls_i, mem_i, tx_rdy_i,
    output we_o, addr_o, mem_o, tx_stb_o, tx_o, tx_len_o, tx_sel_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/capture_ctrl.sv
// ============================================================================
// capture_ctrl
// Circular-buffer capture controller: records samples while armed, captures
// a post-trigger delay, then reads back the newest samples (newest first),
// compacting each word by the byte-group enable mask.
// Revision: 1.0
// ============================================================================
`default_nettype none

module capture_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  capture_ctrl_if.slave bus
);
  localparam int GROUPS   = WIDTH / 8;
  localparam int LW       = $clog2(GROUPS + 1);
  localparam int FULL     = 2 ** DEPTH;
  localparam int RST_READ = (FULL < 4) ? FULL : 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_DELAY = 3'd2,
    S_FETCH = 3'd3,
    S_WAIT  = 3'd4,
    S_SEND  = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [DEPTH-1:0]  wptr, wptr_nxt;
  logic [DEPTH-1:0]  rptr, rptr_nxt;
  logic [17:0]       dcnt, dcnt_nxt;
  logic [DEPTH:0]    rcnt, rcnt_nxt;
  logic              phase, phase_nxt;
  logic              we_nxt;
  logic [DEPTH-1:0]  addr_nxt;
  logic [WIDTH-1:0]  mem_nxt;
  logic              cap;

  logic [17:0]       dinit;      // delay - 1
  logic [DEPTH:0]    rinit;      // clamped read count
  logic [GROUPS-1:0] grp_dis;

  logic [18:0]       read_full;
  logic [DEPTH:0]    read_clamp;
  logic [WIDTH-1:0]  pack_data;
  logic [LW-1:0]     k_w;

  // Read count is clamped to the buffer size when it is loaded
  always_comb begin
    read_full  = {1'b0, bus.cmd_i[15:0], 2'b00} + 19'd4;
    read_clamp = (read_full > 19'(FULL)) ? (DEPTH+1)'(FULL) : read_full[DEPTH:0];
  end

  // Configuration registers, writable only while idle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dinit   <= 18'd3;
      rinit   <= (DEPTH+1)'(RST_READ);
      grp_dis <= '0;
    end else if (state == S_IDLE) begin
      if (bus.set_cnt_i) begin
        dinit <= {bus.cmd_i[31:16], 2'b11};
        rinit <= read_clamp;
      end
      if (bus.set_grp_i) begin
        grp_dis <= bus.grp_dis_i;
      end
    end
  end

  // Pack the enabled byte groups of the RAM word towards the LSB
  always_comb begin
    pack_data = '0;
    k_w       = '0;
    for (int g = 0; g < GROUPS; g++) begin
      if (!grp_dis[g]) begin
        pack_data[k_w*8 +: 8] = bus.mem_i[g*8 +: 8];
        k_w = k_w + LW'(1);
      end
    end
  end

  // Next-state, pointer/counter and RAM-port decode
  always_comb begin
    state_nxt = state;
    wptr_nxt  = wptr;
    rptr_nxt  = rptr;
    dcnt_nxt  = dcnt;
    rcnt_nxt  = rcnt;
    phase_nxt = 1'b0;
    we_nxt    = 1'b0;
    addr_nxt  = bus.addr_o;
    mem_nxt   = bus.mem_o;
    cap       = 1'b0;
    case (state)
      S_IDLE: begin
        wptr_nxt = '0;
        rptr_nxt = '0;
        dcnt_nxt = '0;
        rcnt_nxt = '0;
        if (bus.arm_i) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (bus.stb_i) begin
          we_nxt   = 1'b1;
          addr_nxt = wptr;
          mem_nxt  = bus.smpls_i;
          wptr_nxt = wptr + DEPTH'(1);
          if (bus.run_i) begin
            // Trigger sample is the first of the delay samples
            if (dinit == 18'd0) begin
              state_nxt = S_FETCH;
              rptr_nxt  = wptr;
              rcnt_nxt  = rinit;
            end else begin
              state_nxt = S_DELAY;
              dcnt_nxt  = dinit;
            end
          end
        end
      end
      S_DELAY: begin
        if (bus.stb_i) begin
          we_nxt   = 1'b1;
          addr_nxt = wptr;
          mem_nxt  = bus.smpls_i;
          wptr_nxt = wptr + DEPTH'(1);
          dcnt_nxt = dcnt - 18'd1;
          if (dcnt == 18'd1) begin
            // addr_o already points at the last write, which is rptr
            state_nxt = S_FETCH;
            rptr_nxt  = wptr;
            rcnt_nxt  = rinit;
          end
        end
      end
      S_FETCH: begin
        // Phase 0 presents the address, phase 1 takes the RAM data
        if (!phase) begin
          phase_nxt = 1'b1;
        end else begin
          cap       = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.tx_rdy_i || (bus.tx_len_o == '0)) state_nxt = S_SEND;
      end
      S_SEND: begin
        rptr_nxt = rptr - DEPTH'(1);
        addr_nxt = rptr - DEPTH'(1);
        rcnt_nxt = rcnt - (DEPTH+1)'(1);
        state_nxt = (rcnt == (DEPTH+1)'(1)) ? S_IDLE : S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, pointers, counters and registered RAM port
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      wptr       <= '0;
      rptr       <= '0;
      dcnt       <= '0;
      rcnt       <= '0;
      phase      <= 1'b0;
      bus.we_o   <= 1'b0;
      bus.addr_o <= '0;
      bus.mem_o  <= '0;
    end else begin
      state      <= state_nxt;
      wptr       <= wptr_nxt;
      rptr       <= rptr_nxt;
      dcnt       <= dcnt_nxt;
      rcnt       <= rcnt_nxt;
      phase      <= phase_nxt;
      bus.we_o   <= we_nxt;
      bus.addr_o <= addr_nxt;
      bus.mem_o  <= mem_nxt;
    end
  end

  // Compacted word held from capture until the next capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.tx_o     <= '0;
      bus.tx_len_o <= LW'(GROUPS);
    end else if (cap) begin
      bus.tx_o     <= pack_data;
      bus.tx_len_o <= k_w;
    end
  end

  assign bus.tx_stb_o = (state == S_SEND) && (bus.tx_len_o != '0);
  assign bus.tx_sel_o = (state == S_FETCH) || (state == S_WAIT) || (state == S_SEND);
  assign bus.busy_o   = (state != S_IDLE);

endmodule

`default_nettype wire
